eth_hdr_serializer: RTL and testbench
=====================================

# eth_hdr_serializer

Converts a decoded Ethernet frame into a flat 8-bit AXI-stream byte stream for the MAC TX path. The frame is a header (dest MAC, src MAC, EtherType) plus a payload stream. The block sits directly downstream of the Ethernet arbitrated mux. It consumes the mux's `m_eth_*` header handshake and payload stream, emits the 14 header bytes, then forwards the payload. Output is registered through a two-entry skid buffer, so no combinational path exists from `m_axis_tready` to any input ready.

## Interface
- `USER_WIDTH`, default 1: width of payload `tuser`, passed through unchanged.
- `clk` input, 1 bit: single clock domain for the whole block.
- `rst_n` input, 1 bit: asynchronous reset, active-low.
- `s_eth_hdr_valid` input, 1 bit: header valid.
- `s_eth_hdr_ready` output, 1 bit: header accept.
- `s_eth_dest_mac` input, 48 bits: destination MAC.
- `s_eth_src_mac` input, 48 bits: source MAC.
- `s_eth_type` input, 16 bits: EtherType.
- `s_eth_payload_axis_tdata` input, 8 bits: payload byte.
- `s_eth_payload_axis_tvalid` input, 1 bit: payload valid.
- `s_eth_payload_axis_tready` output, 1 bit: payload accept.
- `s_eth_payload_axis_tlast` input, 1 bit: last payload byte.
- `s_eth_payload_axis_tuser` input, `USER_WIDTH` bits: payload sideband (bad-frame flag).
- `m_axis_tdata` output, 8 bits: serialized byte.
- `m_axis_tvalid` output, 1 bit: output valid.
- `m_axis_tready` input, 1 bit: output accept.
- `m_axis_tlast` output, 1 bit: last byte of frame.
- `m_axis_tuser` output, `USER_WIDTH` bits: sideband for the current byte.
- `busy` output, 1 bit: a frame is in progress (state not IDLE).

## Operation
- **States:** IDLE, HEADER, PAYLOAD. Encoding lives in the package.
- **IDLE**
  - `s_eth_hdr_ready` = (state == IDLE) && !rst; this is combinational from state only.
  - On `s_eth_hdr_valid && s_eth_hdr_ready`: latch dest, src and type into a 112-bit shift register, clear `ptr`, go to HEADER.
- **HEADER**
  - Byte order on the wire: dest[47:40] first through dest[7:0], then src[47:40]…src[7:0], then type[15:8], type[7:0].
  - One byte is pushed into the output stage per cycle in which the internal ready (`tready_int_reg`) is high.
  - Header bytes carry `tlast`=0 and `tuser`=0.
  - `ptr` is 4 bits and counts 0..13. After byte 13 is pushed, go to PAYLOAD.
- **PAYLOAD**
  - `s_eth_payload_axis_tready` = `tready_int_reg`.
  - Each accepted beat is forwarded with its `tdata`, `tlast` and `tuser`.
  - When a beat with `tlast`=1 is accepted, go to IDLE.
- A frame with a one-byte payload is legal. A zero-length payload is not representable; upstream always supplies at least one beat.
- `s_eth_payload_axis_tready` is 0 in IDLE and HEADER. Payload presented early is held off, not dropped.
- Header fields are sampled only at the header handshake. Later changes on `s_eth_*` header inputs are ignored.
- **Output skid buffer:** output register plus temp register.
  - `tready_int_early` = `m_axis_tready` || (!temp_valid && (!out_valid || !int_valid)).
  - `tready_int_early` is registered as `tready_int_reg`.
  - If `m_axis_tready` is held high, throughput is one byte per cycle.

## Timing
- **Reset values:**
  - state=IDLE, `busy`=0, `s_eth_hdr_ready`=0 while `rst_n`=0.
  - `m_axis_tvalid`=0, temp_valid=0, `tready_int_reg`=0, `s_eth_payload_axis_tready`=0.
  - `m_axis_tdata`, `m_axis_tlast` and `m_axis_tuser` read as 0.
- Header accepted at cycle N → state HEADER at N+1 → byte 0 valid on `m_axis` at N+2, given `tready_int_reg` is high.
- **Back-to-back frames:**
  - Last payload beat accepted at T → IDLE at T+1 → next header accepted at T+1 → its byte 0 appears at T+3.
  - This gives exactly one idle output slot between frames when the output never stalls. This gap is required behaviour.
- **Stall:** `m_axis_tready` low for k cycles → at most 2 bytes are buffered. No byte is lost or duplicated, and output order is preserved.
- **Reset mid-frame:** all state clears immediately and asynchronously. The partial frame is truncated without `tlast`; downstream handles this. After `rst_n` deasserts, the first edge gives `tready_int_reg`=1 and the header can be accepted.
- **Simultaneous events:** the payload `tlast` acceptance and an `m_axis` stall in the same cycle → the byte goes to temp, and the state still moves to IDLE.

## Structure
- Package `eth_hdr_pkg`: state enum; `ETH_HDR_LEN`=14; MAC and EtherType widths (48, 16).
- One sub-module, `axis_skid_reg`, with parameter `WIDTH` = 8+1+`USER_WIDTH`. It holds the output/temp register pair and the `tready_int_early` logic.
- The top level holds the FSM, header shift register, `ptr` counter and mux into the skid input.

## Test plan
- **Single frame:** dest=02:00:00:00:00:01, src=02:00:00:00:00:02, type=0x0800, payload 0xAA,0xBB (tlast on 0xBB), `m_axis_tready`=1. Required output is 02 00 00 00 00 01 02 00 00 00 00 02 08 00 AA BB, with `tlast` only on BB and byte 0 at N+2.
- **Back-to-back frames:** two frames with `s_eth_hdr_valid` held high. Required: second header accepted the cycle after the first `tlast`, exactly one idle output cycle between frames, `busy` low for exactly one cycle.
- **Random backpressure:** 50% random `m_axis_tready` over 100 frames of length 1–64. The output must equal a scoreboard byte-for-byte; `m_axis_tdata` must stay stable while valid && !ready.
- **Early payload:** payload `tvalid`=1 with 0x55 before the header. `s_eth_payload_axis_tready` must stay 0 until after the 14th header byte, and 0x55 must appear as byte 14.
- **tuser propagation:** the last payload beat has `tuser`=1. `m_axis_tuser`=1 only on that byte and 0 on all header bytes.
- **Reset mid-frame:** assert `rst_n`=0 during header byte 7. Required: `m_axis_tvalid` and `busy` drop to 0 asynchronously, then a clean new frame follows the release.

Source files
------------

// File: rtl/eth_hdr_pkg.sv
// Shared types and constants for the Ethernet header serializer.
// Holds the FSM encoding, header geometry and the header packing helper.
package eth_hdr_pkg;

    localparam int ETH_HDR_LEN = 14;
    localparam int MAC_WIDTH   = 48;
    localparam int TYPE_WIDTH  = 16;
    localparam int HDR_BITS    = 2 * MAC_WIDTH + TYPE_WIDTH;
    localparam int PTR_WIDTH   = 4;

    localparam logic [PTR_WIDTH-1:0] HDR_LAST_PTR = PTR_WIDTH'(ETH_HDR_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // Wire order is dest MSB first, then src, then EtherType, so the packed
    // word is simply shifted out from its top byte.
    function automatic logic [HDR_BITS-1:0] pack_hdr(
        input logic [MAC_WIDTH-1:0]  dest,
        input logic [MAC_WIDTH-1:0]  src,
        input logic [TYPE_WIDTH-1:0] eth_type
    );
        return {dest, src, eth_type};
    endfunction

endpackage

// File: rtl/eth_hdr_serializer_skid.sv
// Two-entry output stage (output register + temp register) for an AXI-stream.
// The internal ready is registered, so downstream tready never reaches upstream combinationally.
module axis_skid_reg #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_int_data,
    input  logic             i_int_valid,
    output logic             o_int_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_temp_data;
    logic             r_temp_valid;
    logic             r_int_ready;
    logic             w_int_ready_early;

    // Accept next cycle if downstream drains now or at least one slot stays free.
    always_comb begin
        w_int_ready_early = i_ready || (!r_temp_valid && (!r_out_valid || !i_int_valid));
    end

    // Output/temp register pair with registered upstream ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= {WIDTH{1'b0}};
            r_out_valid  <= 1'b0;
            r_temp_data  <= {WIDTH{1'b0}};
            r_temp_valid <= 1'b0;
            r_int_ready  <= 1'b0;
        end else begin
            r_int_ready <= w_int_ready_early;
            if (r_int_ready) begin
                if (i_ready || !r_out_valid) begin
                    r_out_valid <= i_int_valid;
                    r_out_data  <= i_int_data;
                end else begin
                    r_temp_valid <= i_int_valid;
                    r_temp_data  <= i_int_data;
                end
            end else if (i_ready) begin
                r_out_valid  <= r_temp_valid;
                r_out_data   <= r_temp_data;
                r_temp_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign o_int_ready = r_int_ready;
    assign o_data      = r_out_data;
    assign o_valid     = r_out_valid;

endmodule

// File: rtl/eth_hdr_serializer.sv
// Serializes a decoded Ethernet header (dest, src, EtherType) followed by its
// payload stream onto a single 8-bit AXI-stream through a registered skid stage.
module eth_hdr_serializer #(
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [7:0]            s_eth_payload_axis_tdata,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_eth_payload_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  busy
);

    import eth_hdr_pkg::*;

    localparam int SKID_W = 8 + 1 + USER_WIDTH;

    state_t                r_state;
    state_t                w_state_next;
    logic [HDR_BITS-1:0]   r_hdr_shift;
    logic [PTR_WIDTH-1:0]  r_ptr;

    logic                  w_int_ready;
    logic                  w_int_valid;
    logic [7:0]            w_int_data;
    logic                  w_int_last;
    logic [USER_WIDTH-1:0] w_int_user;
    logic                  w_hdr_fire;
    logic                  w_pay_fire;
    logic [SKID_W-1:0]     w_skid_out;

    // Gated by rst_n so the header is never acknowledged while reset is held.
    assign s_eth_hdr_ready = (r_state == ST_IDLE) && rst_n;
    assign w_hdr_fire      = s_eth_hdr_valid && s_eth_hdr_ready;
    assign w_pay_fire      = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign busy            = (r_state != ST_IDLE);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr_fire) begin
                    w_state_next = ST_HEADER;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (w_int_ready && (r_ptr == HDR_LAST_PTR)) begin
                    w_state_next = ST_PAYLOAD;
                end else begin
                    w_state_next = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (w_pay_fire && s_eth_payload_axis_tlast) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_PAYLOAD;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: mux header bytes or payload beats into the skid input.
    always_comb begin
        w_int_valid               = 1'b0;
        w_int_data                = 8'h00;
        w_int_last                = 1'b0;
        w_int_user                = {USER_WIDTH{1'b0}};
        s_eth_payload_axis_tready = 1'b0;
        case (r_state)
            ST_HEADER: begin
                w_int_valid = w_int_ready;
                w_int_data  = r_hdr_shift[HDR_BITS-1 -: 8];
            end
            ST_PAYLOAD: begin
                s_eth_payload_axis_tready = w_int_ready;
                w_int_valid               = s_eth_payload_axis_tvalid && w_int_ready;
                w_int_data                = s_eth_payload_axis_tdata;
                w_int_last                = s_eth_payload_axis_tlast;
                w_int_user                = s_eth_payload_axis_tuser;
            end
            default: begin
                w_int_valid = 1'b0;
            end
        endcase
    end

    // Header shift register and byte pointer; fields are captured only at the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_shift <= {HDR_BITS{1'b0}};
            r_ptr       <= {PTR_WIDTH{1'b0}};
        end else if (w_hdr_fire) begin
            r_hdr_shift <= pack_hdr(s_eth_dest_mac, s_eth_src_mac, s_eth_type);
            r_ptr       <= {PTR_WIDTH{1'b0}};
        end else if ((r_state == ST_HEADER) && w_int_ready) begin
            r_hdr_shift <= {r_hdr_shift[HDR_BITS-9:0], 8'h00};
            r_ptr       <= r_ptr + 4'd1;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    axis_skid_reg #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_int_data  ({w_int_user, w_int_last, w_int_data}),
        .i_int_valid (w_int_valid),
        .o_int_ready (w_int_ready),
        .o_data      (w_skid_out),
        .o_valid     (m_axis_tvalid),
        .i_ready     (m_axis_tready)
    );

    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = w_skid_out;

endmodule

// File: tb/tb_eth_hdr_serializer.sv
// Self-checking bench for eth_hdr_serializer: vector table, scoreboard queue and
// directed sequences for back-to-back, early payload, random backpressure and reset.
`timescale 1ns/1ps
module tb_eth_hdr_serializer;

    typedef struct { logic [47:0] dest; logic [47:0] src; logic [15:0] typ; } hdr_t;
    typedef struct { logic [7:0] d; logic l; logic u; } beat_t;
    typedef struct { logic [7:0] d; logic l; logic u; logic sof; } exp_t;
    typedef struct {
        logic [47:0]  dest;
        logic [47:0]  src;
        logic [15:0]  typ;
        logic [111:0] exp_hdr;
        int           len;
        logic [7:0]   base;
        logic [7:0]   step;
        logic         ulast;
        int           exp_total;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_eth_hdr_valid;
    logic        s_eth_hdr_ready;
    logic [47:0] s_eth_dest_mac;
    logic [47:0] s_eth_src_mac;
    logic [15:0] s_eth_type;
    logic [7:0]  s_eth_payload_axis_tdata;
    logic        s_eth_payload_axis_tvalid;
    logic        s_eth_payload_axis_tready;
    logic        s_eth_payload_axis_tlast;
    logic [0:0]  s_eth_payload_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        busy;

    hdr_t  hdr_q[$];
    beat_t pay_q[$];
    exp_t  exp_q[$];
    int    acc_cyc_q[$];
    int    pay_last_cyc_q[$];
    int    sof_cyc_q[$];
    int    last_out_cyc_q[$];
    int    frame_len_q[$];
    logic  busy_hist [0:65535];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic hdr_fire = 1'b0;
    logic pay_fire = 1'b0;
    logic rdy_random = 1'b0;
    vec_t vec [0:3];

    eth_hdr_serializer #(.USER_WIDTH(1)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (s_eth_payload_axis_tdata),
        .s_eth_payload_axis_tvalid (s_eth_payload_axis_tvalid),
        .s_eth_payload_axis_tready (s_eth_payload_axis_tready),
        .s_eth_payload_axis_tlast  (s_eth_payload_axis_tlast),
        .s_eth_payload_axis_tuser  (s_eth_payload_axis_tuser),
        .m_axis_tdata              (m_axis_tdata),
        .m_axis_tvalid             (m_axis_tvalid),
        .m_axis_tready             (m_axis_tready),
        .m_axis_tlast              (m_axis_tlast),
        .m_axis_tuser              (m_axis_tuser),
        .busy                      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1000;
    endfunction

    task automatic push_hdr(input logic [47:0] dest, input logic [47:0] src,
                            input logic [15:0] typ, input logic [111:0] exp_hdr);
        hdr_t h;
        exp_t e;
        h.dest = dest; h.src = src; h.typ = typ;
        hdr_q.push_back(h);
        for (int k = 0; k < 14; k++) begin
            e.d = exp_hdr[111 - 8 * k -: 8]; e.l = 1'b0; e.u = 1'b0; e.sof = (k == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_pay(input int len, input logic [7:0] base, input logic [7:0] step,
                            input logic ulast, input logic to_drv, input logic to_exp);
        beat_t b;
        exp_t  e;
        for (int j = 0; j < len; j++) begin
            b.d = base + 8'(j) * step;
            b.l = (j == len - 1);
            b.u = ulast && b.l;
            if (to_drv) pay_q.push_back(b);
            e.d = b.d; e.l = b.l; e.u = b.u; e.sof = 1'b0;
            if (to_exp) exp_q.push_back(e);
        end
    endtask

    task automatic clear_logs();
        acc_cyc_q.delete(); pay_last_cyc_q.delete(); sof_cyc_q.delete();
        last_out_cyc_q.delete(); frame_len_q.delete();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() > 0 || hdr_q.size() > 0 || pay_q.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, 128'(n < budget), 128'(1));
        repeat (3) @(negedge clk);
    endtask

    initial begin : cyc_cnt
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin : hdr_drv
        s_eth_hdr_valid = 1'b0; s_eth_dest_mac = 48'h0; s_eth_src_mac = 48'h0; s_eth_type = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (hdr_fire && hdr_q.size() > 0) hdr_q.delete(0);
            if (hdr_q.size() > 0) begin
                s_eth_hdr_valid = 1'b1;
                s_eth_dest_mac  = hdr_q[0].dest;
                s_eth_src_mac   = hdr_q[0].src;
                s_eth_type      = hdr_q[0].typ;
            end else begin
                s_eth_hdr_valid = 1'b0;
            end
        end
    end

    initial begin : pay_drv
        s_eth_payload_axis_tvalid = 1'b0; s_eth_payload_axis_tdata = 8'h0;
        s_eth_payload_axis_tlast = 1'b0; s_eth_payload_axis_tuser = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (pay_fire && pay_q.size() > 0) pay_q.delete(0);
            if (pay_q.size() > 0) begin
                s_eth_payload_axis_tvalid = 1'b1;
                s_eth_payload_axis_tdata  = pay_q[0].d;
                s_eth_payload_axis_tlast  = pay_q[0].l;
                s_eth_payload_axis_tuser  = pay_q[0].u;
            end else begin
                s_eth_payload_axis_tvalid = 1'b0;
            end
        end
    end

    initial begin : rdy_drv
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_axis_tready = rdy_random ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial begin : monitor
        exp_t       e;
        logic       stall_prev = 1'b0;
        logic [9:0] prev_word = 10'h0;
        int         fbytes = 0;
        forever begin
            @(negedge clk);
            if (cyc < 65536) busy_hist[cyc] = busy;
            hdr_fire = rst_n && s_eth_hdr_valid && s_eth_hdr_ready;
            if (hdr_fire) acc_cyc_q.push_back(cyc);
            pay_fire = rst_n && s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
            if (pay_fire && s_eth_payload_axis_tlast) pay_last_cyc_q.push_back(cyc);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("tdata_stable_in_stall", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev_word);
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_beat: got %0h, expected no beat (cycle %0d)", m_axis_tdata, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, {e.d, e.l, e.u});
                        if (e.sof) begin
                            sof_cyc_q.push_back(cyc);
                            fbytes = 0;
                        end
                        fbytes++;
                        if (m_axis_tlast) begin
                            last_out_cyc_q.push_back(cyc);
                            frame_len_q.push_back(fbytes);
                        end
                    end
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                prev_word  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
            end
        end
    end

    initial begin : test
        int n;
        int held;
        int lo;
        int hi;
        int cnt;
        logic [47:0] rd;
        logic [47:0] rs;
        logic [15:0] rt;

        vec[0] = '{48'h020000000001, 48'h020000000002, 16'h0800,
                   112'h020000000001_020000000002_0800, 2, 8'hAA, 8'h11, 1'b0, 16};
        vec[1] = '{48'hFFFFFFFFFFFF, 48'h001122334455, 16'h86DD,
                   112'hFFFFFFFFFFFF_001122334455_86DD, 1, 8'h5A, 8'h00, 1'b0, 15};
        vec[2] = '{48'h0A1B2C3D4E5F, 48'h665544332211, 16'h0806,
                   112'h0A1B2C3D4E5F_665544332211_0806, 5, 8'h01, 8'h01, 1'b1, 19};
        vec[3] = '{48'h123456789ABC, 48'hDEF012345678, 16'h88CC,
                   112'h123456789ABC_DEF012345678_88CC, 3, 8'hF0, 8'h08, 1'b1, 17};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_hdr_ready", s_eth_hdr_ready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_pay_tready", s_eth_payload_axis_tready, 0);
        check("rst_tdata_tlast_tuser", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, 10'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_hdr_ready", s_eth_hdr_ready, 1);
        check("post_rst_pay_tready", s_eth_payload_axis_tready, 0);

        // Table-driven single frames, full-rate output
        for (int i = 0; i < 4; i++) begin
            clear_logs();
            push_hdr(vec[i].dest, vec[i].src, vec[i].typ, vec[i].exp_hdr);
            push_pay(vec[i].len, vec[i].base, vec[i].step, vec[i].ulast, 1'b1, 1'b1);
            wait_drain(500, "table");
            check("table_byte0_latency", 128'(qget(sof_cyc_q, 0) - qget(acc_cyc_q, 0)), 128'(2));
            check("table_frame_len", 128'(qget(frame_len_q, 0)), 128'(vec[i].exp_total));
        end

        // Early payload is held off until after the 14th header byte
        clear_logs();
        push_pay(1, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (s_eth_payload_axis_tready) cnt++;
        end
        check("early_tready_low_in_idle", 128'(cnt), 128'(0));
        push_hdr(48'hA0A1A2A3A4A5, 48'hB0B1B2B3B4B5, 16'h0800, 112'hA0A1A2A3A4A5_B0B1B2B3B4B5_0800);
        push_pay(1, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!(s_eth_hdr_valid && s_eth_hdr_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = 0;
        @(negedge clk);
        while (!s_eth_payload_axis_tready && held < 100) begin
            held++;
            @(negedge clk);
        end
        check("early_tready_hold_cycles", 128'(held), 128'(14));
        wait_drain(500, "early");
        check("early_frame_len", 128'(qget(frame_len_q, 0)), 128'(15));

        // Back-to-back frames with header valid held high
        clear_logs();
        push_hdr(48'h111111111111, 48'h222222222222, 16'h0800, 112'h111111111111_222222222222_0800);
        push_pay(3, 8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
        push_hdr(48'h333333333333, 48'h444444444444, 16'h0806, 112'h333333333333_444444444444_0806);
        push_pay(2, 8'h20, 8'h01, 1'b1, 1'b1, 1'b1);
        wait_drain(500, "b2b");
        check("b2b_hdr_after_tlast", 128'(qget(acc_cyc_q, 1) - qget(pay_last_cyc_q, 0)), 128'(1));
        check("b2b_idle_slot", 128'(qget(sof_cyc_q, 1) - qget(last_out_cyc_q, 0)), 128'(2));
        lo = qget(acc_cyc_q, 0) + 1;
        hi = qget(acc_cyc_q, 1) + 1;
        cnt = 0;
        for (int c = lo; c <= hi && c >= 0 && c < 65536; c++) begin
            if (!busy_hist[c]) cnt++;
        end
        check("b2b_busy_low_cycles", 128'(cnt), 128'(1));

        // Random backpressure over 100 frames
        clear_logs();
        rdy_random = 1'b1;
        for (int f = 0; f < 100; f++) begin
            rd = 48'({$urandom(), $urandom()});
            rs = 48'({$urandom(), $urandom()});
            rt = 16'($urandom());
            push_hdr(rd, rs, rt, {rd, rs, rt});
            push_pay(int'($urandom_range(1, 64)), 8'($urandom()), 8'($urandom()),
                     1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end
        wait_drain(40000, "random");
        rdy_random = 1'b0;
        check("random_frame_count", 128'(frame_len_q.size()), 128'(100));

        // Reset asserted while header byte 7 is on the output
        repeat (3) @(negedge clk);
        clear_logs();
        push_hdr(48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5, 16'h0800, 112'hC0C1C2C3C4C5_D0D1D2D3D4D5_0800);
        push_pay(4, 8'h70, 8'h01, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (!(s_eth_hdr_valid && s_eth_hdr_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (9) @(negedge clk);
        check("rst_mid_byte7_valid", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'hD1});
        #1;
        rst_n = 1'b0;
        hdr_q.delete(); pay_q.delete(); exp_q.delete();
        hdr_fire = 1'b0; pay_fire = 1'b0;
        #1;
        check("rst_mid_tvalid_async", m_axis_tvalid, 0);
        check("rst_mid_busy_async", busy, 0);
        check("rst_mid_hdr_ready", s_eth_hdr_ready, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        push_hdr(48'h0E0E0E0E0E0E, 48'h0F0F0F0F0F0F, 16'h0800, 112'h0E0E0E0E0E0E_0F0F0F0F0F0F_0800);
        push_pay(2, 8'h99, 8'h01, 1'b1, 1'b1, 1'b1);
        wait_drain(500, "post_rst");
        check("post_rst_byte0_latency", 128'(qget(sof_cyc_q, 0) - qget(acc_cyc_q, 0)), 128'(2));
        check("post_rst_frame_len", 128'(qget(frame_len_q, 0)), 128'(16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
